membus_arb: RTL and testbench

Two-port arbiter and sequencer for the single shared memory/IO bus of the mycpu core. Port C serves the CPU control path (instruction fetch, LD/ST, IOR/IOW); port D serves a DMA/debug loader. It selects one requester per transfer, drives the bus, times the fixed read latency and returns read data to the owner. Fairness is round-robin, with a bounded burst lock for port D.

---
 rtl/mycpu_pkg.sv | 20 ++
 rtl/membus_arb.sv | 151 +++++++++++++++
 tb/tb_membus_arb.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared types and constants for the mycpu memory bus arbiter
package mycpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RDWT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int ARB_RD_LAT_MAX = 3;
  localparam int ARB_BURST_W    = 4;
  // Read-wait counter only ever holds RD_LAT-1, so it is sized for the largest legal latency
  localparam int ARB_RDCNT_W    = $clog2(ARB_RD_LAT_MAX);

endpackage

// File: rtl/membus_arb.sv
// rtl/membus_arb.sv - two-port round-robin arbiter and sequencer for the shared memory bus
module membus_arb
  import mycpu_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req_in,
  input  logic          c_wen_in,
  input  logic [AW-1:0] c_addr_in,
  input  logic [DW-1:0] c_wdata_in,
  input  logic          d_req_in,
  input  logic          d_wen_in,
  input  logic [AW-1:0] d_addr_in,
  input  logic [DW-1:0] d_wdata_in,
  input  logic          d_lock_in,
  output logic          c_gnt_out,
  output logic          d_gnt_out,
  output logic          c_rvalid_out,
  output logic          d_rvalid_out,
  output logic [DW-1:0] c_rdata_out,
  output logic [DW-1:0] d_rdata_out,
  output logic          mem_req_out,
  output logic          mem_wen_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in
);

  localparam logic [ARB_BURST_W-1:0] BURST_SAT   = ARB_BURST_W'(MAX_BURST);
  localparam logic [ARB_RDCNT_W-1:0] RD_CNT_INIT = ARB_RDCNT_W'(RD_LAT - 1);

  arb_state_t             state_q,  state_d;
  arb_owner_t             owner_q,  owner_d;
  arb_owner_t             last_q,   last_d;
  logic                   lock_q,   lock_d;
  logic [ARB_BURST_W-1:0] burst_q,  burst_d;
  logic [ARB_RDCNT_W-1:0] rd_cnt_q, rd_cnt_d;

  logic          lock_act;
  arb_owner_t    pick;
  logic          own_wen;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          in_xfer;
  logic          rv_fire;

  // Lock only counts while port D asked for it last time and the burst is not yet spent
  assign lock_act = lock_q && (burst_q < BURST_SAT);

  // Winner of the current request pair; only consulted while IDLE
  always_comb begin
    pick = OWN_C;
    if (c_req_in && d_req_in) begin
      if (lock_act || (last_q == OWN_C)) begin
        pick = OWN_D;
      end
    end else if (d_req_in) begin
      pick = OWN_D;
    end
  end

  assign own_wen   = (owner_q == OWN_D) ? d_wen_in   : c_wen_in;
  assign own_addr  = (owner_q == OWN_D) ? d_addr_in  : c_addr_in;
  assign own_wdata = (owner_q == OWN_D) ? d_wdata_in : c_wdata_in;

  // Next-state: arbitration in IDLE, read/write split in XFER, latency countdown in RDWT
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    lock_d   = lock_q;
    burst_d  = burst_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!d_req_in) begin
          burst_d = '0;
        end
        if (c_req_in || d_req_in) begin
          owner_d = pick;
          last_d  = pick;
          state_d = XFER;
          if ((pick == OWN_D) && lock_act) begin
            burst_d = burst_q + 1'b1;
          end else begin
            burst_d = '0;
          end
        end
      end
      XFER: begin
        if (owner_q == OWN_D) begin
          lock_d = d_lock_in;
        end
        if (own_wen) begin
          rd_cnt_d = RD_CNT_INIT;
          state_d  = RDWT;
        end else begin
          state_d = IDLE;
        end
      end
      RDWT: begin
        if (rd_cnt_q != '0) begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight and favours C on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_C;
      last_q   <= OWN_D;
      lock_q   <= 1'b0;
      burst_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      lock_q   <= lock_d;
      burst_q  <= burst_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign in_xfer = (state_q == XFER);
  assign rv_fire = (state_q == RDWT) && (rd_cnt_q == '0);

  assign mem_req_out   = in_xfer;
  assign mem_wen_out   = in_xfer ? own_wen   : 1'b1;
  assign mem_addr_out  = in_xfer ? own_addr  : '0;
  assign mem_wdata_out = in_xfer ? own_wdata : '0;

  assign c_gnt_out    = in_xfer && (owner_q == OWN_C);
  assign d_gnt_out    = in_xfer && (owner_q == OWN_D);
  assign c_rvalid_out = rv_fire && (owner_q == OWN_C);
  assign d_rvalid_out = rv_fire && (owner_q == OWN_D);
  assign c_rdata_out  = c_rvalid_out ? mem_rdata_in : '0;
  assign d_rdata_out  = d_rvalid_out ? mem_rdata_in : '0;

endmodule

// File: tb/tb_membus_arb.sv
// tb/tb_membus_arb.sv - self-checking bench for membus_arb
module tb_membus_arb;

  localparam int DW        = 16;
  localparam int AW        = 16;
  localparam int MAX_BURST = 4;
  localparam int MAIN      = 1;
  localparam int MAIN_LAT  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          c_req = 1'b0, d_req = 1'b0, c_wen = 1'b1, d_wen = 1'b1, d_lock = 1'b0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0, mem_rdata = '0;

  logic          c_gnt_v [3];
  logic          d_gnt_v [3];
  logic          c_rv_v  [3];
  logic          d_rv_v  [3];
  logic [DW-1:0] c_rd_v  [3];
  logic [DW-1:0] d_rd_v  [3];
  logic          m_req_v [3];
  logic          m_wen_v [3];
  logic [AW-1:0] m_addr_v[3];
  logic [DW-1:0] m_wd_v  [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    membus_arb #(.DW(DW), .AW(AW), .RD_LAT(g + 1), .MAX_BURST(MAX_BURST)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .c_req_in     (c_req),
      .c_wen_in     (c_wen),
      .c_addr_in    (c_addr),
      .c_wdata_in   (c_wdata),
      .d_req_in     (d_req),
      .d_wen_in     (d_wen),
      .d_addr_in    (d_addr),
      .d_wdata_in   (d_wdata),
      .d_lock_in    (d_lock),
      .c_gnt_out    (c_gnt_v[g]),
      .d_gnt_out    (d_gnt_v[g]),
      .c_rvalid_out (c_rv_v[g]),
      .d_rvalid_out (d_rv_v[g]),
      .c_rdata_out  (c_rd_v[g]),
      .d_rdata_out  (d_rd_v[g]),
      .mem_req_out  (m_req_v[g]),
      .mem_wen_out  (m_wen_v[g]),
      .mem_addr_out (m_addr_v[g]),
      .mem_wdata_out(m_wd_v[g]),
      .mem_rdata_in (mem_rdata)
    );
  end

  int errors = 0;
  int checks = 0;

  // Transaction-level model: cycle numbers of the grant, the read return and the next free cycle
  int cyc       = 0;
  int xfer_p    = -1;
  int rv_p      = -1;
  int free_from = 0;
  bit m_own     = 1'b0;
  bit m_last    = 1'b1;
  bit m_lockf   = 1'b0;
  int m_burst   = 0;
  bit lock_on;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      xfer_p    = -1;
      rv_p      = -1;
      free_from = 0;
      m_last    = 1'b1;
      m_burst   = 0;
      m_lockf   = 1'b0;
    end else begin
      if (cyc == xfer_p) begin
        if (m_own) m_lockf = d_lock;
        if ((m_own ? d_wen : c_wen) == 1'b1) begin
          rv_p      = cyc + MAIN_LAT;
          free_from = rv_p + 1;
        end else begin
          free_from = cyc + 1;
        end
      end else if (cyc >= free_from) begin
        if (c_req || d_req) begin
          lock_on = m_lockf && (m_burst < MAX_BURST);
          if (c_req && d_req) m_own = lock_on ? 1'b1 : !m_last;
          else                m_own = d_req;
          m_burst   = (m_own && lock_on) ? m_burst + 1 : 0;
          m_last    = m_own;
          xfer_p    = cyc + 1;
          free_from = 1 << 30;
        end else begin
          m_burst = 0;
        end
      end
      cyc++;
    end
  end

  // Every cycle: the main instance's outputs against the model
  logic          cx, cr, e_wen;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  initial forever begin
    @(negedge clk);
    cx     = (cyc == xfer_p);
    cr     = (cyc == rv_p);
    e_wen  = m_own ? d_wen   : c_wen;
    e_addr = m_own ? d_addr  : c_addr;
    e_wd   = m_own ? d_wdata : c_wdata;
    chk("c_gnt",     32'(c_gnt_v[MAIN]),  32'(cx && !m_own));
    chk("d_gnt",     32'(d_gnt_v[MAIN]),  32'(cx && m_own));
    chk("c_rvalid",  32'(c_rv_v[MAIN]),   32'(cr && !m_own));
    chk("d_rvalid",  32'(d_rv_v[MAIN]),   32'(cr && m_own));
    chk("c_rdata",   32'(c_rd_v[MAIN]),   (cr && !m_own) ? 32'(mem_rdata) : 32'd0);
    chk("d_rdata",   32'(d_rd_v[MAIN]),   (cr && m_own)  ? 32'(mem_rdata) : 32'd0);
    chk("mem_req",   32'(m_req_v[MAIN]),  32'(cx));
    chk("mem_wen",   32'(m_wen_v[MAIN]),  cx ? 32'(e_wen)  : 32'd1);
    chk("mem_addr",  32'(m_addr_v[MAIN]), cx ? 32'(e_addr) : 32'd0);
    chk("mem_wdata", 32'(m_wd_v[MAIN]),   cx ? 32'(e_wd)   : 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    c_req = 1'b0;
    d_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_gnt(input bit port_d, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (port_d ? d_gnt_v[MAIN] : c_gnt_v[MAIN]) break;
      n++;
      if (n > 20) begin
        errors++;
        checks++;
        $display("FAIL wait_gnt: no grant within 20 cycles (port_d=%0d)", port_d);
        break;
      end
    end
  endtask

  task automatic collect(input int n, output logic [15:0] seq, output int got);
    got = 0;
    seq = '0;
    for (int i = 0; i < 80 && got < n; i++) begin
      @(negedge clk);
      if (c_gnt_v[MAIN]) begin
        seq[got] = 1'b0;
        got++;
      end else if (d_gnt_v[MAIN]) begin
        seq[got] = 1'b1;
        got++;
      end
    end
  endtask

  int          lat_n, got, cnt_c, cnt_d, cnt_m;
  logic [15:0] seq;
  int          g_at[3];
  int          r_at[3];
  logic        cg, dg;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_mem_wen", 32'(m_wen_v[MAIN]), 32'd1);
    chk("rst_mem_req", 32'(m_req_v[MAIN]), 32'd0);
    chk("rst_c_gnt",   32'(c_gnt_v[MAIN]), 32'd0);
    chk("rst_addr",    32'(m_addr_v[MAIN]), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Single C write
    c_req = 1'b1; c_wen = 1'b0; c_addr = 16'h0040; c_wdata = 16'h1234;
    wait_gnt(1'b0, lat_n);
    chk("wr_latency", 32'(lat_n),           32'd1);
    chk("wr_mem_req", 32'(m_req_v[MAIN]),   32'd1);
    chk("wr_mem_wen", 32'(m_wen_v[MAIN]),   32'd0);
    chk("wr_addr",    32'(m_addr_v[MAIN]),  32'h0040);
    chk("wr_wdata",   32'(m_wd_v[MAIN]),    32'h1234);
    tick();
    c_req = 1'b0;
    @(negedge clk);
    chk("wr_idle_req", 32'(m_req_v[MAIN]), 32'd0);
    chk("wr_idle_gnt", 32'(c_gnt_v[MAIN]), 32'd0);
    idle(6);

    // D read latency on RD_LAT = 1, 2, 3
    for (int k = 0; k < 3; k++) begin g_at[k] = -100; r_at[k] = -200; end
    d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0100; mem_rdata = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (d_gnt_v[k]) g_at[k] = i;
        if (d_rv_v[k]) begin
          r_at[k] = i;
          chk("sweep_d_rdata", 32'(d_rd_v[k]), 32'hBEEF);
          chk("sweep_c_rdata", 32'(c_rd_v[k]), 32'd0);
        end
      end
      tick();
      if (g_at[0] >= 0) d_req = 1'b0;
    end
    for (int k = 0; k < 3; k++) chk("sweep_latency", 32'(r_at[k] - g_at[k]), 32'(k + 1));
    idle(6);

    // Reset in the middle of a C read, then round-robin from a fresh reset
    c_req = 1'b1; c_wen = 1'b1; c_addr = 16'h0010;
    wait_gnt(1'b0, lat_n);
    tick();
    rst_n = 1'b0;
    c_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rd_c_rvalid", 32'(c_rv_v[MAIN]),  32'd0);
      chk("rst_rd_c_rdata",  32'(c_rd_v[MAIN]),  32'd0);
      chk("rst_rd_mem_req",  32'(m_req_v[MAIN]), 32'd0);
      chk("rst_rd_mem_wen",  32'(m_wen_v[MAIN]), 32'd1);
      tick();
    end
    rst_n = 1'b1;
    c_req = 1'b1; c_wen = 1'b1; c_addr = 16'h0020;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0030; d_lock = 1'b0;
    collect(4, seq, got);
    chk("rr_count", 32'(got), 32'd4);
    chk("rr_seq",   32'(seq), 32'b1010);
    tick();
    idle(8);

    // Burst lock: prime the lock with a lone D write, then contend
    d_req = 1'b1; d_wen = 1'b0; d_lock = 1'b1; d_addr = 16'h0200; d_wdata = 16'h0D0D;
    wait_gnt(1'b1, lat_n);
    tick();
    c_req = 1'b1; c_wen = 1'b0; c_addr = 16'h0204; c_wdata = 16'h0C0C;
    collect(10, seq, got);
    chk("burst_count", 32'(got), 32'd10);
    chk("burst_seq",   32'(seq), 32'h01EF);
    tick();
    d_lock = 1'b0;
    idle(8);

    // One-cycle C request pulse
    c_req = 1'b1; c_wen = 1'b0; c_addr = 16'h0300; c_wdata = 16'h55AA;
    tick();
    c_req = 1'b0;
    cnt_c = 0; cnt_d = 0; cnt_m = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (c_gnt_v[MAIN]) cnt_c++;
      if (d_gnt_v[MAIN]) cnt_d++;
      if (m_req_v[MAIN]) cnt_m++;
    end
    chk("drop_c_grants", 32'(cnt_c), 32'd1);
    chk("drop_d_grants", 32'(cnt_d), 32'd0);
    chk("drop_bus_cyc",  32'(cnt_m), 32'd1);
    idle(4);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cg = c_gnt_v[MAIN];
      dg = d_gnt_v[MAIN];
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      if (c_req && !cg) begin
        if ($urandom_range(0, 39) == 0) c_req = 1'b0;
      end else begin
        c_req   = ($urandom_range(0, 2) != 0);
        c_wen   = 1'($urandom);
        c_addr  = 16'($urandom);
        c_wdata = 16'($urandom);
      end
      if (d_req && !dg) begin
        if ($urandom_range(0, 39) == 0) d_req = 1'b0;
      end else begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_wen   = 1'($urandom);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      d_lock    = ($urandom_range(0, 3) != 0);
      mem_rdata = 16'($urandom);
    end
    rst_n = 1'b1;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
